morse_rx: RTL and testbench



---
 rtl/morse_rx.sv | 182 ++++++++++++++++++
 tb/tb_morse_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/morse_rx.sv
// Morse receiver: samples key_in once per unit, measures mark/gap lengths and
// decodes letters J..Q. Optional input synchronizer: define MORSE_RX_SYNC_EN.
module morse_rx #(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_in,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       error,
    output logic       busy
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LOAD = CW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        GAP,
        EMIT,
        FLUSH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tick_cnt_q;
    logic          tick;
    logic          key;
    logic [2:0]    run_q, run_d;
    logic [2:0]    sym_cnt_q, sym_cnt_d;
    logic [3:0]    sym_sh_q, sym_sh_d;
    logic [2:0]    letter_q, letter_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [3:0]    dec;

`ifdef MORSE_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], key_in};
        end
    end

    assign key = sync_q[1];
`else
    assign key = key_in;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= TICK_LOAD;
        end else if (tick) begin
            tick_cnt_q <= TICK_LOAD;
        end else begin
            tick_cnt_q <= tick_cnt_q - 1'b1;
        end
    end

    assign tick = (tick_cnt_q == '0);

    // Returns {hit, code}; symbols are packed oldest-first toward the MSB.
    function automatic logic [3:0] decode(input logic [2:0] n, input logic [3:0] sh);
        logic [3:0] r;
        case ({n, sh})
            {3'd4, 4'b0111}: r = 4'b1_001;
            {3'd3, 4'b0101}: r = 4'b1_010;
            {3'd4, 4'b0100}: r = 4'b1_011;
            {3'd2, 4'b0011}: r = 4'b1_100;
            {3'd2, 4'b0010}: r = 4'b1_101;
            {3'd3, 4'b0111}: r = 4'b1_110;
            {3'd4, 4'b0110}: r = 4'b1_111;
            {3'd4, 4'b1101}: r = 4'b1_000;
            default:         r = 4'b0_000;
        endcase
        return r;
    endfunction

    assign dec = decode(sym_cnt_q, sym_sh_q);

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        sym_cnt_d = sym_cnt_q;
        sym_sh_d  = sym_sh_q;
        letter_d  = letter_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick && key) begin
                    state_d   = MARK;
                    run_d     = 3'd1;
                    sym_cnt_d = '0;
                    sym_sh_d  = '0;
                end
            end
            MARK: begin
                if (tick) begin
                    if (key) begin
                        run_d = (run_q == 3'd7) ? run_q : run_q + 3'd1;
                    end else if (run_q >= 3'd4 || sym_cnt_q == 3'd4) begin
                        // The key=0 tick that ends the bad mark is the first flush unit.
                        state_d = FLUSH;
                        err_d   = 1'b1;
                        run_d   = 3'd1;
                    end else begin
                        sym_sh_d  = {sym_sh_q[2:0], (run_q != 3'd1)};
                        sym_cnt_d = sym_cnt_q + 3'd1;
                        state_d   = GAP;
                        run_d     = 3'd1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (key) begin
                        state_d = MARK;
                        run_d   = 3'd1;
                    end else begin
                        run_d = run_q + 3'd1;
                        if (run_q == 3'd2) begin
                            state_d = EMIT;
                        end
                    end
                end
            end
            EMIT: begin
                if (dec[3]) begin
                    letter_d = dec[2:0];
                    valid_d  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            FLUSH: begin
                if (tick) begin
                    if (key) begin
                        run_d = '0;
                    end else if (run_q == 3'd2) begin
                        state_d = IDLE;
                    end else begin
                        run_d = run_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            run_q     <= '0;
            sym_cnt_q <= '0;
            sym_sh_q  <= '0;
            letter_q  <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            sym_cnt_q <= sym_cnt_d;
            sym_sh_q  <= sym_sh_d;
            letter_q  <= letter_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign letter       = letter_q;
    assign letter_valid = valid_q;
    assign error        = err_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_morse_rx.sv
// Bench for morse_rx: directed letter patterns plus random words, checked
// against a string-based Morse model of expected letter/error events.
module tb_morse_rx;

    localparam int unsigned TICK_DIV = 4;
`ifdef MORSE_RX_SYNC_EN
    localparam int unsigned SYNC_LAT = 2;
`else
    localparam int unsigned SYNC_LAT = 0;
`endif

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       key_in = 1'b0;
    logic [2:0] letter;
    logic       letter_valid;
    logic       error;
    logic       busy;

    morse_rx #(.TICK_DIV(TICK_DIV)) dut (
        .clock       (clock),
        .reset       (reset),
        .key_in      (key_in),
        .letter      (letter),
        .letter_valid(letter_valid),
        .error       (error),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Event codes: 0..7 = letter_valid with that letter, 8 = error pulse.
    int          obs_ev[$];
    int unsigned obs_cyc[$];
    int          exp_ev[$];
    logic        prev_lv  = 1'b0;
    logic        prev_err = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            if (letter_valid) begin
                check_eq("excl", 32'(error), 32'd0);
                check_eq("lv_width", 32'(prev_lv), 32'd0);
                obs_ev.push_back(int'(letter));
                obs_cyc.push_back(cyc);
            end
            if (error) begin
                check_eq("err_width", 32'(prev_err), 32'd0);
                obs_ev.push_back(8);
                obs_cyc.push_back(cyc);
            end
        end
        prev_lv  = letter_valid;
        prev_err = error;
    end

    string codes_tbl[8] = '{"--.-", ".---", "-.-", ".-..", "--", "-.", "---", ".--."};

    function automatic int model_word(input int marks[$]);
        string pat;
        pat = "";
        foreach (marks[i]) begin
            if (marks[i] >= 4 || pat.len() == 4) return 8;
            if (marks[i] == 1) pat = {pat, "."};
            else               pat = {pat, "-"};
        end
        for (int c = 0; c < 8; c++) begin
            if (pat == codes_tbl[c]) return c;
        end
        return 8;
    endfunction

    bit          first_unit = 1'b1;
    int unsigned last_drive = 0;
    int unsigned word_units = 0;

    // Drives one Morse unit so that the receiver's tick samples it.
    task automatic send_unit(input logic b);
        if (first_unit) begin
            repeat (TICK_DIV - 1 - SYNC_LAT) @(posedge clock);
            first_unit = 1'b0;
        end else begin
            repeat (TICK_DIV) @(posedge clock);
        end
        @(negedge clock);
        key_in     = b;
        last_drive = cyc;
    endtask

    task automatic word_unit(input logic b);
        send_unit(b);
        word_units++;
        if (word_units == 2) check_eq("busy_mark", 32'(busy), 32'd1);
    endtask

    task automatic send_word(input int marks[$], input int trail, output int unsigned gap3);
        gap3       = 0;
        word_units = 0;
        exp_ev.push_back(model_word(marks));
        foreach (marks[i]) begin
            for (int u = 0; u < marks[i]; u++) word_unit(1'b1);
            if (i != marks.size() - 1) word_unit(1'b0);
        end
        for (int t = 0; t < trail; t++) begin
            word_unit(1'b0);
            if (t == 2) gap3 = last_drive;
        end
    endtask

    task automatic letter_marks(input string s, input int dash, output int m[$]);
        m = {};
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "-") m.push_back(dash == 0 ? int'($urandom_range(2, 3)) : dash);
            else             m.push_back(1);
        end
    endtask

    task automatic compare_events(input string tag);
        int n;
        repeat (3) send_unit(1'b0);
        check_eq({tag, "_count"}, 32'(obs_ev.size()), 32'(exp_ev.size()));
        n = (obs_ev.size() < exp_ev.size()) ? obs_ev.size() : exp_ev.size();
        for (int i = 0; i < n; i++) check_eq(tag, 32'(obs_ev[i]), 32'(exp_ev[i]));
        obs_ev  = {};
        obs_cyc = {};
        exp_ev  = {};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          m[$];
        int unsigned g3;

        repeat (3) @(negedge clock);
        check_eq("rst_letter", 32'(letter), 32'd0);
        check_eq("rst_valid", 32'(letter_valid), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset      = 1'b1;
        first_unit = 1'b1;

        repeat (20) send_unit(1'b0);
        check_eq("idle_events", 32'(obs_ev.size()), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // J 1011101110111000
        m = {1, 3, 3, 3};
        send_word(m, 3, g3);
        repeat (3) send_unit(1'b0);
        if (obs_cyc.size() > 0) check_eq("j_latency", 32'(obs_cyc[0] - g3), 32'(2 + SYNC_LAT));
        compare_events("J");

        for (int k = 0; k < 8; k++) begin
            letter_marks(codes_tbl[(k + 1) % 8], 3, m);
            send_word(m, 3, g3);
        end
        compare_events("seq8");

        m = {4};
        send_word(m, 3, g3);
        m = {3, 1, 3};
        send_word(m, 7, g3);
        compare_events("badmark");

        m = {1, 1, 1, 1, 1};
        send_word(m, 5, g3);
        m = {1};
        send_word(m, 3, g3);
        compare_events("fivedot");

        send_unit(1'b1);
        send_unit(1'b1);
        send_unit(1'b1);
        send_unit(1'b0);
        send_unit(1'b1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("mid_letter", 32'(letter), 32'd0);
        check_eq("mid_valid", 32'(letter_valid), 32'd0);
        check_eq("mid_error", 32'(error), 32'd0);
        check_eq("mid_busy", 32'(busy), 32'd0);
        key_in = 1'b0;
        repeat (3) @(negedge clock);
        reset      = 1'b1;
        first_unit = 1'b1;
        m = {3, 3};
        send_word(m, 9, g3);
        compare_events("reset_m");

        for (int w = 0; w < 40; w++) begin
            if ($urandom_range(0, 9) < 6) begin
                letter_marks(codes_tbl[$urandom_range(0, 7)], 0, m);
            end else begin
                m = {};
                for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
                    m.push_back(($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(1, 5)));
                end
            end
            send_word(m, int'($urandom_range(3, 5)), g3);
        end
        compare_events("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
